// File: rtl/register_file_8x16.sv
// -----------------------------------------------------------------------------
// register_file_8x16
//
// Purpose:
//   Eight-entry, 16-bit general-purpose register file for the single-cycle
//   RISC datapath. It has one clocked write port with address decode and two
//   independent combinational read ports that feed the ALU operand paths.
//   R0 is hardwired to zero: writes to address 0 are dropped and reads of
//   address 0 return zero.
//
// Configuration macro:
//   REGFILE_WRITE_BYPASS_EN - when defined, a pending write (LOAD=1, WA!=0)
//   is forwarded combinationally to any read port whose address matches WA.
//   The forwarding is suppressed while rst=1. Storage timing is unchanged.
//
// Ports:
//   clk   in   1           rising-edge clock
//   rst   in   1           synchronous, active-high reset (clears R1..R7)
//   LOAD  in   1           write enable, sampled on the rising edge
//   WA    in   ADDR_WIDTH  write address
//   WD    in   DATA_WIDTH  write data
//   RA1   in   ADDR_WIDTH  read address, port 1
//   RA2   in   ADDR_WIDTH  read address, port 2
//   RD1   out  DATA_WIDTH  read data, port 1 (combinational)
//   RD2   out  DATA_WIDTH  read data, port 2 (combinational)
// -----------------------------------------------------------------------------
module register_file_8x16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  LOAD,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [ADDR_WIDTH-1:0] RA1,
  input  logic [ADDR_WIDTH-1:0] RA2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

  // R0 has no storage at all; only R1..R(NUM_REGS-1) are real flops.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  logic                  write_hit;
  logic [DATA_WIDTH-1:0] rd1_stored;
  logic [DATA_WIDTH-1:0] rd2_stored;
  logic [DATA_WIDTH-1:0] rd1_sel;
  logic [DATA_WIDTH-1:0] rd2_sel;

  // A write is effective only with LOAD high and a non-zero target address.
  assign write_hit = LOAD && (WA != ZERO_ADDR);

  // Next-state: hold every register, replace only the addressed one.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_hit) begin
      regs_d[WA] = WD;
    end else begin
      regs_d[1] = regs_q[1];
    end
  end

  // Storage update; reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= ZERO_DATA;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Stored-value read muxes; address 0 decodes to the constant-zero entry.
  always_comb begin
    rd1_stored = ZERO_DATA;
    rd2_stored = ZERO_DATA;
    if (RA1 != ZERO_ADDR) begin
      rd1_stored = regs_q[RA1];
    end else begin
      rd1_stored = ZERO_DATA;
    end
    if (RA2 != ZERO_ADDR) begin
      rd2_stored = regs_q[RA2];
    end else begin
      rd2_stored = ZERO_DATA;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  // Forward the in-flight write so the same instruction sees the new value;
  // a pending reset means the write will be lost, so do not forward it.
  always_comb begin
    rd1_sel = rd1_stored;
    rd2_sel = rd2_stored;
    if (!rst && write_hit && (RA1 == WA)) begin
      rd1_sel = WD;
    end else begin
      rd1_sel = rd1_stored;
    end
    if (!rst && write_hit && (RA2 == WA)) begin
      rd2_sel = WD;
    end else begin
      rd2_sel = rd2_stored;
    end
  end
`else
  // Read ports reflect stored contents only.
  always_comb begin
    rd1_sel = rd1_stored;
    rd2_sel = rd2_stored;
  end
`endif

  assign RD1 = rd1_sel;
  assign RD2 = rd2_sel;

endmodule
